instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
IF stage of the 5-stage pipelined CPU. Owns the PC, issues instruction-memory requests and presents IF_PC/IF_Instruction to the IF/ID pipeline register. Handles a variable-latency instruction memory (req held until rvalid), pipeline stalls from the hazard unit, and branch redirects from later stages. Invalid or flushed slots are presented as NOP.

Parameters:
RESET_PC, 64'h0, PC loaded on reset
NOP_INSTR, 32'hD503201F, encoding driven when no valid instruction

Ports:
clk  in  1  clock, all state rising-edge
reset  in  1  asynchronous, active-high
stall  in  1  downstream not capturing this cycle; hold current instruction
redirect  in  1  branch taken / flush request
redirect_pc  in  64  new fetch target when redirect=1
imem_req  out  1  fetch request; held with imem_addr until imem_rvalid
imem_addr  out  64  fetch address
imem_rvalid  in  1  response valid; may arrive same cycle as req
imem_rdata  in  32  instruction data, qualified by imem_rvalid
IF_PC  out  64  PC of presented instruction
IF_Instruction  out  32  presented instruction or NOP_INSTR
IF_Valid  out  1  presented instruction is real

Behaviour:
- Registers: pc (next fetch), req_addr (outstanding address), buf_instr/buf_pc, 2-bit state.
- Reset (async): state=S_BOOT, pc=req_addr=RESET_PC, buffer cleared; outputs imem_req=0, imem_addr=RESET_PC, IF_Valid=0, IF_Instruction=NOP_INSTR, IF_PC=RESET_PC.
- S_BOOT: one cycle, imem_req=0, IF_Valid=0; -> S_FETCH. redirect here loads pc=redirect_pc.
- S_FETCH: imem_req=1, imem_addr=pc, req_addr tracks pc. IF_Valid=imem_rvalid, IF_Instruction=rvalid?imem_rdata:NOP_INSTR, IF_PC=pc (combinational, zero-wait memory yields 1 instr/cycle).
  - rvalid & !stall & !redirect: pc<=pc+4, stay.
  - rvalid & stall & !redirect: buf<=rdata/pc, -> S_HOLD.
  - !rvalid: stay, pc unchanged.
- S_HOLD: imem_req=0; IF_Valid=1, IF_Instruction=buf_instr, IF_PC=buf_pc. !stall: pc<=pc+4, -> S_FETCH. stall: stay.
- S_DROP: request in flight for stale address: imem_req=1, imem_addr=req_addr, IF_Valid=0, NOP presented. On rvalid: discard data, -> S_FETCH (pc already holds redirect target).
- redirect (highest priority, any state): IF_Valid forced 0 and NOP presented that cycle; pc<=redirect_pc; buffer cleared. Next state: S_DROP if in S_FETCH/S_DROP with !imem_rvalid this cycle, else S_FETCH. redirect & stall together: redirect wins.
- redirect in S_DROP: pc updated to newest target, stay S_DROP.
- PC arithmetic: 64-bit unsigned, +4 wraps modulo 2^64; redirect_pc low 2 bits used as given.
- imem_addr/imem_req never change while a request is unanswered (memory contract).

Optional Feature:
IF_PERF_CNT_EN: adds outputs perf_fetched[31:0] (increments on each cycle IF_Valid&!stall&!redirect) and perf_bubbles[31:0] (increments on each cycle IF_Valid=0 after S_BOOT). Both reset to 0, saturate at 32'hFFFFFFFF. Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
- fetch_pkg: NOP_INSTR default constant, state enum {S_BOOT,S_FETCH,S_HOLD,S_DROP}, PC_INC=64'd4.
- Storage uses the existing DFF_multi (with wr_en) for pc, req_addr, buffer; no further sub-module.

Test Plan:
- Reset RESET_PC=0, zero-wait memory returning rvalid same cycle -> cycle0 IF_Valid=0; then IF_PC=0,4,8,... one per cycle, imem_addr matches.
- Memory with 3-cycle latency -> imem_req/addr stable for 3 cycles, IF_Valid pulses once per 3 cycles, PC steps by 4.
- stall asserted 2 cycles as rdata 32'h8B020020 arrives at PC 0x10 -> S_HOLD, imem_req=0, IF_Instruction=32'h8B020020, IF_PC=0x10 held; after release fetch resumes at 0x14.
- redirect to 0x100 while 0x20 request outstanding (latency 2) -> IF_Valid=0, late 0x20 data discarded, next request addr=0x100.
- redirect and stall same cycle in S_HOLD -> buffer cleared, NOP presented, next fetch 0x100.
- reset asserted mid-request at PC 0x40 -> outputs immediately reset values, fetch restarts at RESET_PC after one S_BOOT cycle; pc=0xFFFFFFFFFFFFFFFC advance wraps to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage constants (default NOP encoding, PC step) and the fetch state encoding
package fetch_pkg;
  localparam logic [31:0] NOP_DEFAULT = 32'hD503201F;
  localparam logic [63:0] PC_INC = 64'd4;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DROP} state_t;
endpackage

// File: rtl/dff_multi.sv
// DFF_multi: WIDTH-bit register with write enable (wr_en), async active-high reset to RST_VAL; ports clk, reset, wr_en, d, q
module DFF_multi #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= RST_VAL;
    else if (wr_en) q <= d;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage owning pc, driving imem_req/imem_addr until imem_rvalid, holding on stall, dropping stale fetches on redirect and presenting IF_PC/IF_Instruction/IF_Valid (NOP when invalid); `define IF_PERF_CNT_EN adds perf_fetched/perf_bubbles saturating counters
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_PC,
  output logic [31:0] IF_Instruction,
  output logic        IF_Valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  state_t state, state_nxt;
  logic [63:0] pc, pc_nxt, req_addr, buf_pc;
  logic [31:0] buf_instr;
  logic pc_we, buf_we;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_BOOT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    pc_we = 1'b0;
    pc_nxt = pc + PC_INC;
    buf_we = 1'b0;
    imem_req = 1'b0;
    imem_addr = req_addr;
    IF_Valid = 1'b0;
    IF_Instruction = NOP_INSTR;
    IF_PC = pc;
    case (state)
      S_BOOT: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        imem_addr = pc;
        IF_Valid = imem_rvalid;
        IF_Instruction = imem_rvalid ? imem_rdata : NOP_INSTR;
        pc_we = imem_rvalid && !stall;
        buf_we = imem_rvalid && stall;
        state_nxt = imem_rvalid && stall ? S_HOLD : S_FETCH;
      end
      S_HOLD: begin
        IF_Valid = 1'b1;
        IF_Instruction = buf_instr;
        IF_PC = buf_pc;
        pc_we = !stall;
        state_nxt = stall ? S_HOLD : S_FETCH;
      end
      S_DROP: begin
        imem_req = 1'b1;
        state_nxt = imem_rvalid ? S_FETCH : S_DROP;
      end
      default: state_nxt = S_BOOT;
    endcase
    if (redirect) begin
      IF_Valid = 1'b0;
      IF_Instruction = NOP_INSTR;
      pc_we = 1'b1;
      pc_nxt = redirect_pc;
      buf_we = 1'b1;
      state_nxt = (state == S_FETCH || state == S_DROP) && !imem_rvalid ? S_DROP : S_FETCH;
    end
  end
  DFF_multi #(.WIDTH(64), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .wr_en(pc_we), .d(pc_nxt), .q(pc)
  );
  DFF_multi #(.WIDTH(64), .RST_VAL(RESET_PC)) u_req_addr (
    .clk(clk), .reset(reset), .wr_en(state == S_FETCH), .d(pc), .q(req_addr)
  );
  DFF_multi #(.WIDTH(96), .RST_VAL({NOP_INSTR, RESET_PC})) u_buf (
    .clk(clk), .reset(reset), .wr_en(buf_we),
    .d(redirect ? {NOP_INSTR, RESET_PC} : {imem_rdata, pc}),
    .q({buf_instr, buf_pc})
  );
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (IF_Valid && !stall && !redirect && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (!IF_Valid && state != S_BOOT && !(&perf_bubbles)) perf_bubbles <= perf_bubbles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch stimulus checked against an instruction-stream reference model
module tb_instruction_fetch_unit;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [63:0] redirect_pc = '0, imem_addr, IF_PC;
  logic imem_req, imem_rvalid, IF_Valid;
  logic [31:0] imem_rdata, IF_Instruction;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif
  int checks = 0, failures = 0;
  int lat_fix = 0, lat_cur = 0, cnt = 0, idle = 0;
  logic [63:0] exp_pc = '0, held_pc = '0, prev_addr = '0;
  logic [31:0] held_instr = '0;
  logic held = 1'b0, prev_pend = 1'b0;
  localparam logic [31:0] NOP = 32'hD503201F;
  always #5 clk = ~clk;
  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_PC(IF_PC), .IF_Instruction(IF_Instruction), .IF_Valid(IF_Valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );
  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return a == 64'h10 ? 32'h8B020020 : (a[33:2] * 32'h9E3779B9) ^ a[63:32];
  endfunction
  assign imem_rvalid = imem_req && cnt >= lat_cur;
  assign imem_rdata = imem_rvalid ? mem_fn(imem_addr) : 32'hDEADBEEF;
  always @(posedge clk or posedge reset)
    if (reset) cnt <= 0;
    else if (imem_rvalid) begin
      cnt <= 0;
      lat_cur <= lat_fix < 0 ? int'($urandom_range(3)) : lat_fix;
    end else if (imem_req) cnt <= cnt + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic s, input logic r, input logic [63:0] p);
    stall = s;
    redirect = r;
    redirect_pc = p;
    #1;
  endtask
  task automatic clear_model();
    exp_pc = '0;
    held = 1'b0;
    prev_pend = 1'b0;
    idle = 0;
  endtask
  task automatic tick();
    if (prev_pend) begin
      check("req_hold", 64'(imem_req), 64'd1);
      check("addr_hold", imem_addr, prev_addr);
    end
    if (redirect) begin
      check("redir_valid", 64'(IF_Valid), 64'd0);
      check("redir_nop", 64'(IF_Instruction), 64'(NOP));
      exp_pc = redirect_pc;
      held = 1'b0;
      idle = 0;
    end else if (IF_Valid) begin
      if (held) begin
        check("hold_req", 64'(imem_req), 64'd0);
        check("hold_pc", IF_PC, held_pc);
        check("hold_instr", 64'(IF_Instruction), 64'(held_instr));
      end
      check("pc", IF_PC, exp_pc);
      check("instr", 64'(IF_Instruction), 64'(mem_fn(exp_pc)));
      idle = 0;
      if (stall) begin
        held = 1'b1;
        held_pc = IF_PC;
        held_instr = IF_Instruction;
      end else begin
        held = 1'b0;
        exp_pc = exp_pc + 64'd4;
      end
    end else begin
      if (held) check("hold_valid", 64'(IF_Valid), 64'd1);
      check("nop", 64'(IF_Instruction), 64'(NOP));
      idle++;
      if (idle > 12) begin
        check("progress", 64'(idle), 64'd0);
        idle = 0;
      end
    end
    prev_pend = imem_req && !imem_rvalid;
    prev_addr = imem_addr;
    @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(imem_req), 64'd0);
    check({tag, "_addr"}, imem_addr, 64'd0);
    check({tag, "_valid"}, 64'(IF_Valid), 64'd0);
    check({tag, "_instr"}, 64'(IF_Instruction), 64'(NOP));
    check({tag, "_pc"}, IF_PC, 64'd0);
  endtask
  initial begin
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    step(0, 0, 0);
    check("boot_valid", 64'(IF_Valid), 64'd0);
    check("boot_req", 64'(imem_req), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      check("zw_valid", 64'(IF_Valid), 64'd1);
      check("zw_pc", IF_PC, 64'(i * 4));
      check("zw_addr", imem_addr, 64'(i * 4));
      tick();
    end
    step(1, 0, 0);
    check("stall_instr", 64'(IF_Instruction), 64'h8B020020);
    tick();
    step(1, 0, 0);
    check("hold_req0", 64'(imem_req), 64'd0);
    check("hold_pc10", IF_PC, 64'h10);
    check("hold_ins", 64'(IF_Instruction), 64'h8B020020);
    tick();
    lat_fix = 2;
    step(0, 0, 0);
    tick();
    step(0, 0, 0);
    check("resume_addr", imem_addr, 64'h14);
    check("resume_valid", 64'(IF_Valid), 64'd1);
    tick();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) begin
        step(0, 0, 0);
        check("lat_req", 64'(imem_req), 64'd1);
        check("lat_addr", imem_addr, 64'h18 + 64'(k * 4));
        check("lat_valid", 64'(IF_Valid), 64'(j == 2));
        tick();
      end
    step(0, 1, 64'h100);
    check("rd_addr20", imem_addr, 64'h20);
    tick();
    lat_fix = 0;
    step(0, 0, 0);
    check("drop_addr", imem_addr, 64'h20);
    check("drop_valid", 64'(IF_Valid), 64'd0);
    tick();
    step(0, 0, 0);
    check("drop_late", 64'(IF_Valid), 64'd0);
    tick();
    step(0, 0, 0);
    check("new_addr", imem_addr, 64'h100);
    check("new_valid", 64'(IF_Valid), 64'd1);
    tick();
    step(1, 0, 0);
    tick();
    step(1, 1, 64'h100);
    check("rs_valid", 64'(IF_Valid), 64'd0);
    check("rs_nop", 64'(IF_Instruction), 64'(NOP));
    tick();
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("rs_next", imem_addr, 64'h100);
    tick();
    step(0, 0, 0);
    check("wrap_top", IF_PC, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    lat_fix = 3;
    step(0, 1, 64'h40);
    check("wrap_zero", imem_addr, 64'd0);
    tick();
    step(0, 0, 0);
    check("mid_addr", imem_addr, 64'h40);
    check("mid_valid", 64'(IF_Valid), 64'd0);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    lat_fix = -1;
    step(0, 0, 0);
    check("reboot_valid", 64'(IF_Valid), 64'd0);
    check("reboot_req", 64'(imem_req), 64'd0);
    tick();
    step(0, 0, 0);
    check("restart_addr", imem_addr, 64'd0);
    tick();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(3) == 0, $urandom_range(9) == 0,
           $urandom_range(3) == 0 ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3)) * 64'd4
                                  : {$urandom, $urandom} & ~64'h3);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
